loc_sram_wr_coalescer: RTL

- Upstream stage of the 256-row x 1280-bit local SRAM (8-bit row address, 256 lanes x 5 bits, active-low write strobe, per-lane keep mask).
- Accepts a stream of (vid, 5-bit value) updates and gathers them into one row buffer.
- Issues a single masked row write per row, when the row changes, when the row is full, or on an explicit flush.
- Turns scattered per-vertex updates into full-width SRAM writes.

---
 rtl/loc_sram_wr_coalescer_pkg.sv | 23 ++
 rtl/loc_sram_wr_coalescer_if.sv | 25 ++
 rtl/loc_sram_wr_coalescer_row_buffer.sv | 87 ++++++++
 rtl/loc_sram_wr_coalescer.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/loc_sram_wr_coalescer_pkg.sv
// Shared parameters, FSM state type and lane placement helper for the
// local-SRAM write coalescer.
package loc_sram_pkg;

    localparam int ADDR_SPACE = 8;
    localparam int BW         = 5;
    localparam int D          = 256;
    localparam int LANE_W     = 8;
    localparam int VID_W      = ADDR_SPACE + LANE_W;
    localparam int CNT_W      = LANE_W + 1;

    typedef enum logic [1:0] {
        EMPTY      = 2'd0,
        FILL       = 2'd1,
        FLUSH_DONE = 2'd2
    } state_e;

    // Lane 0 sits at the MSB end of the row word.
    function automatic int unsigned lane_off(input logic [LANE_W-1:0] lane);
        return int'(unsigned'(D - 1 - int'(lane))) * BW;
    endfunction

endpackage

// File: rtl/loc_sram_wr_coalescer_if.sv
// Upstream update stream plus flush handshake into the coalescer.
interface loc_sram_wr_coalescer_if
    import loc_sram_pkg::*;
();

    logic             in_valid;
    logic             in_ready;
    logic [VID_W-1:0] in_vid;
    logic [BW-1:0]    in_data;
    logic             flush;
    logic             flush_done;

    // Producer side: drives updates and flush requests.
    modport master (
        output in_valid, in_vid, in_data, flush,
        input  in_ready, flush_done
    );

    // Coalescer side.
    modport slave (
        input  in_valid, in_vid, in_data, flush,
        output in_ready, flush_done
    );

endinterface

// File: rtl/loc_sram_wr_coalescer_row_buffer.sv
// Row gather buffer: lane data, per-lane keep bits and count of distinct
// lanes written. Data and keep are stored in SRAM layout so they can be
// handed straight to the write port.
module loc_row_buffer
    import loc_sram_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [LANE_W-1:0] lane_i,
    input  logic [BW-1:0]     data_i,
    output logic [D*BW-1:0]   data_o,
    output logic [D-1:0]      keep_o,
    output logic [D*BW-1:0]   merged_data_o,
    output logic [D-1:0]      merged_keep_o,
    output logic              full_o
);

    logic [D*BW-1:0]  data_q, data_d;
    logic [D-1:0]     keep_q, keep_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [D*BW-1:0]  merged_data, fresh_data;
    logic [D-1:0]     merged_keep, fresh_keep;
    logic [CNT_W-1:0] merged_cnt;
    logic [LANE_W-1:0] keep_idx;
    logic             new_lane;

    // Buffer contents with the incoming lane merged in, and a fresh buffer
    // holding only the incoming lane (used on a row change).
    always_comb begin
        keep_idx    = ~lane_i;
        new_lane    = keep_q[keep_idx];
        merged_data = data_q;
        merged_keep = keep_q;
        merged_data[lane_off(lane_i) +: BW] = data_i;
        merged_keep[keep_idx] = 1'b0;
        merged_cnt  = cnt_q + CNT_W'(new_lane);
        fresh_data  = '0;
        fresh_keep  = '1;
        fresh_data[lane_off(lane_i) +: BW] = data_i;
        fresh_keep[keep_idx] = 1'b0;
    end

    // Next-state selection: clear wins over merge; clear+load restarts.
    always_comb begin
        data_d = data_q;
        keep_d = keep_q;
        cnt_d  = cnt_q;
        if (clear_i) begin
            if (load_i) begin
                data_d = fresh_data;
                keep_d = fresh_keep;
                cnt_d  = CNT_W'(1);
            end else begin
                data_d = '0;
                keep_d = '1;
                cnt_d  = '0;
            end
        end else if (load_i) begin
            data_d = merged_data;
            keep_d = merged_keep;
            cnt_d  = merged_cnt;
        end
    end

    // Buffer registers; reset empties the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            keep_q <= '1;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            keep_q <= keep_d;
            cnt_q  <= cnt_d;
        end
    end

    assign data_o        = data_q;
    assign keep_o        = keep_q;
    assign merged_data_o = merged_data;
    assign merged_keep_o = merged_keep;
    assign full_o        = (merged_cnt == CNT_W'(D));

endmodule

// File: rtl/loc_sram_wr_coalescer.sv
// Gathers scattered (vid, value) updates into one row buffer and emits a
// single masked full-width SRAM write per row: on row change, on a full
// row, or on a flush request.
module loc_sram_wr_coalescer
    import loc_sram_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    loc_sram_wr_coalescer_if.slave up,
    output logic                   sram_wsb,
    output logic [ADDR_SPACE-1:0]  sram_waddr,
    output logic [D*BW-1:0]        sram_wdata,
    output logic [D-1:0]           sram_bytemask,
    output logic [15:0]            row_writes
);

    state_e                state_q, state_d;
    logic [ADDR_SPACE-1:0] cur_row_q, cur_row_d;
    logic                  flush_armed_q, flush_armed_d;
    logic                  flush_done_q, flush_done_d;
    logic                  sram_wsb_q, sram_wsb_d;
    logic [ADDR_SPACE-1:0] sram_waddr_q, sram_waddr_d;
    logic [D*BW-1:0]       sram_wdata_q, sram_wdata_d;
    logic [D-1:0]          sram_bytemask_q, sram_bytemask_d;
    logic [15:0]           row_writes_q, row_writes_d;

    logic [ADDR_SPACE-1:0] row;
    logic [LANE_W-1:0]     lane;
    logic                  accept;
    logic                  flush_req;

    logic                  buf_load, buf_clear, buf_full;
    logic [D*BW-1:0]       buf_data, buf_merged_data;
    logic [D-1:0]          buf_keep, buf_merged_keep;

    assign row       = up.in_vid[VID_W-1:LANE_W];
    assign lane      = up.in_vid[LANE_W-1:0];
    assign accept    = up.in_valid & ~up.flush;
    // A held flush counts once; it re-arms only after flush drops.
    assign flush_req = up.flush & flush_armed_q;

    assign up.in_ready   = ~up.flush;
    assign up.flush_done = flush_done_q;

    loc_row_buffer u_row_buffer (
        .clk           (clk),
        .rst_n         (rst_n),
        .load_i        (buf_load),
        .clear_i       (buf_clear),
        .lane_i        (lane),
        .data_i        (up.in_data),
        .data_o        (buf_data),
        .keep_o        (buf_keep),
        .merged_data_o (buf_merged_data),
        .merged_keep_o (buf_merged_keep),
        .full_o        (buf_full)
    );

    // FSM next state, buffer control and next values of the SRAM write port.
    always_comb begin
        state_d         = state_q;
        cur_row_d       = cur_row_q;
        flush_armed_d   = ~up.flush | flush_armed_q;
        flush_done_d    = (state_q == FLUSH_DONE);
        sram_wsb_d      = 1'b1;
        sram_waddr_d    = sram_waddr_q;
        sram_wdata_d    = sram_wdata_q;
        sram_bytemask_d = '1;
        buf_load        = 1'b0;
        buf_clear       = 1'b0;

        case (state_q)
            EMPTY, FLUSH_DONE: begin
                if (flush_req) begin
                    flush_armed_d = 1'b0;
                    state_d       = FLUSH_DONE;
                end else if (accept) begin
                    buf_load  = 1'b1;
                    cur_row_d = row;
                    state_d   = FILL;
                end else begin
                    state_d   = EMPTY;
                end
            end
            FILL: begin
                if (flush_req) begin
                    sram_wsb_d      = 1'b0;
                    sram_waddr_d    = cur_row_q;
                    sram_wdata_d    = buf_data;
                    sram_bytemask_d = buf_keep;
                    buf_clear       = 1'b1;
                    flush_armed_d   = 1'b0;
                    state_d         = FLUSH_DONE;
                end else if (accept) begin
                    if (row != cur_row_q) begin
                        // Old row goes out while the new lane starts a fresh buffer.
                        sram_wsb_d      = 1'b0;
                        sram_waddr_d    = cur_row_q;
                        sram_wdata_d    = buf_data;
                        sram_bytemask_d = buf_keep;
                        buf_clear       = 1'b1;
                        buf_load        = 1'b1;
                        cur_row_d       = row;
                    end else if (buf_full) begin
                        // Last missing lane: write the merged row directly.
                        sram_wsb_d      = 1'b0;
                        sram_waddr_d    = cur_row_q;
                        sram_wdata_d    = buf_merged_data;
                        sram_bytemask_d = buf_merged_keep;
                        buf_clear       = 1'b1;
                        state_d         = EMPTY;
                    end else begin
                        buf_load        = 1'b1;
                    end
                end
            end
            default: state_d = EMPTY;
        endcase

        row_writes_d = sram_wsb_d ? row_writes_q : row_writes_q + 16'd1;
    end

    // FSM state and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= EMPTY;
            cur_row_q       <= '0;
            flush_armed_q   <= 1'b1;
            flush_done_q    <= 1'b0;
            sram_wsb_q      <= 1'b1;
            sram_waddr_q    <= '0;
            sram_wdata_q    <= '0;
            sram_bytemask_q <= '1;
            row_writes_q    <= '0;
        end else begin
            state_q         <= state_d;
            cur_row_q       <= cur_row_d;
            flush_armed_q   <= flush_armed_d;
            flush_done_q    <= flush_done_d;
            sram_wsb_q      <= sram_wsb_d;
            sram_waddr_q    <= sram_waddr_d;
            sram_wdata_q    <= sram_wdata_d;
            sram_bytemask_q <= sram_bytemask_d;
            row_writes_q    <= row_writes_d;
        end
    end

    assign sram_wsb      = sram_wsb_q;
    assign sram_waddr    = sram_waddr_q;
    assign sram_wdata    = sram_wdata_q;
    assign sram_bytemask = sram_bytemask_q;
    assign row_writes    = row_writes_q;

endmodule
